// File: rtl/fft_frame_arbiter_if.sv
// Signal bundle between fft_frame_arbiter and the input FIFOs, the FFT engine
// and the result FIFOs. The arbiter side is the master modport.
interface fft_frame_arbiter_if #(
  parameter int CNT_W = 7
);
  logic             start;
  logic [CNT_W-1:0] usedw1a;
  logic [CNT_W-1:0] usedw1b;
  logic             empty1a;
  logic             empty1b;
  logic [CNT_W-1:0] usedw2Re;
  logic [CNT_W-1:0] usedw4a;
  logic             full2Re;
  logic             full4a;
  logic             fft_valid_out;
  logic             rdreq1a;
  logic             rdreq1b;
  logic             selmuxFIFO;
  logic             selmuxFFT;
  logic             fft_enable;
  logic             fft_sop;
  logic             fft_eop;
  logic             wrreq2;
  logic             wrreq4a;
  logic             busy;
  logic             frame_done;
  logic             err;

  modport master (
    input  start, usedw1a, usedw1b, empty1a, empty1b,
           usedw2Re, usedw4a, full2Re, full4a, fft_valid_out,
    output rdreq1a, rdreq1b, selmuxFIFO, selmuxFFT, fft_enable, fft_sop,
           fft_eop, wrreq2, wrreq4a, busy, frame_done, err
  );

  modport slave (
    output start, usedw1a, usedw1b, empty1a, empty1b,
           usedw2Re, usedw4a, full2Re, full4a, fft_valid_out,
    input  rdreq1a, rdreq1b, selmuxFIFO, selmuxFFT, fft_enable, fft_sop,
           fft_eop, wrreq2, wrreq4a, busy, frame_done, err
  );
endinterface

// File: rtl/fft_frame_arbiter.sv
// Whole-frame arbiter sharing one FFT between input FIFOs 1a/1b and routing results
// to 2Re/4a. Optional drain watchdog: define FFT_ARB_WATCHDOG_EN.
module fft_frame_arbiter #(
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = 7,
  parameter int DEPTH     = 128,
  parameter int TIMEOUT   = 255
) (
  input  logic                clock,
  input  logic                reset,
  fft_frame_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, ARB, LOAD, DRAIN, DONE} state_t;

  localparam logic [CNT_W:0]   FILL_MIN = (CNT_W+1)'(FRAME_LEN);
  localparam logic [CNT_W:0]   ROOM_MAX = (CNT_W+1)'(DEPTH - FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  if (FRAME_LEN < 1 || FRAME_LEN >= (1 << CNT_W) || DEPTH < FRAME_LEN ||
      TIMEOUT >= (1 << (CNT_W + 1))) begin : g_param_check
    $error("fft_frame_arbiter: parameter out of range for CNT_W");
  end

  state_t           state, state_nx;
  logic             grant;       // 0 = channel a (1a -> 2Re), 1 = channel b (1b -> 4a)
  logic             last_grant;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic             elig_a, elig_b, any_elig, arb_pick;
  logic             rd_fire, wr_fire, wd_trip;
  logic             enable_q, sop_q, eop_q;

  // Zero-extend fills so the room limit (DEPTH-FRAME_LEN) can never wrap.
  assign elig_a = ({1'b0, bus.usedw1a} >= FILL_MIN) && !bus.empty1a &&
                  ({1'b0, bus.usedw2Re} <= ROOM_MAX) && !bus.full2Re;
  assign elig_b = ({1'b0, bus.usedw1b} >= FILL_MIN) && !bus.empty1b &&
                  ({1'b0, bus.usedw4a} <= ROOM_MAX) && !bus.full4a;
  assign any_elig = elig_a || elig_b;
  assign arb_pick = (elig_a && elig_b) ? ~last_grant : elig_b;

  always_comb begin
    // NOTE: defaults first, so no branch of the case below can infer a latch.
    state_nx       = state;
    rd_fire        = 1'b0;
    wr_fire        = 1'b0;
    bus.frame_done = 1'b0;
    case (state)
      IDLE:  if (bus.start && any_elig) state_nx = ARB;
      ARB:   state_nx = any_elig ? LOAD : IDLE;
      LOAD: begin
        rd_fire = grant ? !bus.empty1b : !bus.empty1a;
        if (rd_fire && rd_cnt == LAST_IDX) state_nx = DRAIN;
      end
      DRAIN: begin
        wr_fire = bus.fft_valid_out;
        if (wd_trip) begin
          bus.frame_done = 1'b1;
          state_nx       = IDLE;
        end else if (wr_fire && wr_cnt == LAST_IDX) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.frame_done = 1'b1;
        state_nx       = (bus.start && any_elig) ? ARB : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      enable_q   <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ARB && any_elig) begin
        grant      <= arb_pick;
        last_grant <= arb_pick;
        rd_cnt     <= '0;
        wr_cnt     <= '0;
      end
      if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
      if (wr_fire) wr_cnt <= wr_cnt + 1'b1;
      // FIFO data appears one clock after rdreq, so the FFT strobes trail it by one.
      enable_q <= rd_fire;
      sop_q    <= rd_fire && (rd_cnt == '0);
      eop_q    <= rd_fire && (rd_cnt == LAST_IDX);
    end
  end

`ifdef FFT_ARB_WATCHDOG_EN
  localparam logic [CNT_W:0] WD_LIMIT = (CNT_W+1)'(TIMEOUT);

  logic [CNT_W:0] idle_cnt;
  logic           err_q;

  assign wd_trip = (state == DRAIN) && (idle_cnt == WD_LIMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != DRAIN || bus.fft_valid_out) idle_cnt <= '0;
      else                                     idle_cnt <= idle_cnt + 1'b1;
      if (wd_trip) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign wd_trip = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.rdreq1a    = rd_fire && !grant;
  assign bus.rdreq1b    = rd_fire &&  grant;
  assign bus.wrreq2     = wr_fire && !grant;
  assign bus.wrreq4a    = wr_fire &&  grant;
  assign bus.selmuxFIFO = grant;
  assign bus.selmuxFFT  = grant;
  assign bus.fft_enable = enable_q;
  assign bus.fft_sop    = sop_q;
  assign bus.fft_eop    = eop_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Self-checking bench for fft_frame_arbiter: directed corner cases plus randomized
// rounds checked against a frame-level reference model of eligibility and tie-break.
`timescale 1ns/1ps
module tb_fft_frame_arbiter;
  localparam int FRAME_LEN = 64;
  localparam int CNT_W     = 7;
  localparam int DEPTH     = 128;
  localparam int TIMEOUT   = 255;

  typedef struct {
    int u1a; bit e1a; int u1b; bit e1b;
    int u2;  bit f2;  int u4;  bit f4;
    bit st;
  } stim_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fft_frame_arbiter_if #(.CNT_W(CNT_W)) bus ();

  fft_frame_arbiter #(
    .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit model_last = 1'b1;

  function automatic bit eligible(input int fill, input bit empty, input int used, input bit full);
    return (fill >= FRAME_LEN) && !empty && (used <= DEPTH - FRAME_LEN) && !full;
  endfunction

  function automatic bit pick(input bit ea, input bit eb);
    if (ea && eb) return !model_last;
    return eb;
  endfunction

  function automatic logic [11:0] outs();
    return {bus.rdreq1a, bus.rdreq1b, bus.selmuxFIFO, bus.selmuxFFT, bus.fft_enable,
            bus.fft_sop, bus.fft_eop, bus.wrreq2, bus.wrreq4a, bus.busy,
            bus.frame_done, bus.err};
  endfunction

  // ---------------- cycle monitor ----------------
  int rd_a = 0, rd_b = 0, wr_2 = 0, wr_4 = 0, done_cnt = 0, en_cnt = 0;
  bit prev_rd = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      prev_rd = 1'b0;
      en_cnt  = 0;
    end else begin
      check("rd_mutex", bus.rdreq1a & bus.rdreq1b, 0);
      check("wr_mutex", bus.wrreq2 & bus.wrreq4a, 0);
      check("enable_lag", bus.fft_enable, prev_rd);
      if (bus.fft_enable) begin
        en_cnt++;
        check("sop", bus.fft_sop, en_cnt == 1);
        check("eop", bus.fft_eop, en_cnt == FRAME_LEN);
      end else begin
        check("sop_quiet", bus.fft_sop, 0);
        check("eop_quiet", bus.fft_eop, 0);
      end
      if (bus.wrreq2 | bus.wrreq4a) check("wr_needs_valid", bus.fft_valid_out, 1);
      if (bus.rdreq1a) rd_a++;
      if (bus.rdreq1b) rd_b++;
      if (bus.wrreq2)  wr_2++;
      if (bus.wrreq4a) wr_4++;
      if (bus.frame_done) begin
        done_cnt++;
        check("enables_per_frame", en_cnt, FRAME_LEN);
        en_cnt = 0;
      end
      prev_rd = bus.rdreq1a | bus.rdreq1b;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic settle();
    @(negedge clock); #1;
  endtask

  task automatic drive(input stim_t s);
    bus.usedw1a  = CNT_W'(s.u1a);
    bus.empty1a  = s.e1a;
    bus.usedw1b  = CNT_W'(s.u1b);
    bus.empty1b  = s.e1b;
    bus.usedw2Re = CNT_W'(s.u2);
    bus.full2Re  = s.f2;
    bus.usedw4a  = CNT_W'(s.u4);
    bus.full4a   = s.f4;
    bus.start    = s.st;
  endtask

  task automatic expect_idle(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      if (c > 0) begin tick(); settle(); end
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_rd"}, bus.rdreq1a | bus.rdreq1b, 0);
    end
  endtask

  // One granted frame: LOAD with optional stalls, then DRAIN fed by a random FFT model.
  task automatic do_frame(input bit ch, input bit keep_start, input int stall_at,
                          input int stall_pct, input int abort_at, input bit idle_drain);
    int r0_a = rd_a, r0_b = rd_b, w0_2 = wr_2, w0_4 = wr_4, d0 = done_cnt;
    int reads = 0, stall_left = 0, sent = 0, wrote;
    bit stall_used = 1'b0, empty_now;
    model_last = ch;

    for (int c = 0; c < 600 && reads < FRAME_LEN; c++) begin
      tick();
      empty_now = 1'b0;
      if (reads > 0) begin
        if (reads == stall_at && !stall_used) begin
          stall_used = 1'b1;
          stall_left = 3;
        end
        if (stall_left > 0) begin
          empty_now = 1'b1;
          stall_left--;
        end else begin
          empty_now = ($urandom_range(99) < stall_pct);
        end
      end
      if (ch) bus.empty1b = empty_now; else bus.empty1a = empty_now;
      bus.fft_valid_out = $urandom_range(1);
      settle();
      if (reads > 0) check("load_rd", ch ? bus.rdreq1b : bus.rdreq1a, !empty_now);
      if (reads == 0 && (rd_a - r0_a) + (rd_b - r0_b) > 0) begin
        check("sel_fifo", bus.selmuxFIFO, ch);
        check("sel_fft", bus.selmuxFFT, ch);
      end
      reads = ch ? rd_b - r0_b : rd_a - r0_a;
    end
    check("load_reads", reads, FRAME_LEN);
    check("load_other_rd", ch ? rd_a - r0_a : rd_b - r0_b, 0);
    check("load_no_wr", (wr_2 - w0_2) + (wr_4 - w0_4), 0);

    tick();
    if (ch) bus.empty1b = 1'b0; else bus.empty1a = 1'b0;
    if (!keep_start) bus.start = 1'b0;
    bus.fft_valid_out = 1'b0;
    settle();

    if (idle_drain) begin
      for (int c = 0; c < TIMEOUT + 45; c++) begin tick(); settle(); end
`ifdef FFT_ARB_WATCHDOG_EN
      check("wd_done", done_cnt - d0, 1);
      check("wd_err", bus.err, 1);
      check("wd_idle", bus.busy, 0);
      return;
`else
      check("drain_hold_busy", bus.busy, 1);
      check("drain_hold_err", bus.err, 0);
      check("drain_hold_done", done_cnt - d0, 0);
`endif
    end

    for (int c = 0; c < 4000 && sent < FRAME_LEN; c++) begin
      tick();
      bus.fft_valid_out = ($urandom_range(99) < 60);
      if (bus.fft_valid_out) sent++;
      settle();
      wrote = ch ? wr_4 - w0_4 : wr_2 - w0_2;
      check("drain_track", wrote, sent);
      if (abort_at >= 0 && wrote == abort_at) return;
    end
    tick();
    bus.fft_valid_out = 1'b0;
    settle();
    check("frame_done", bus.frame_done, 1);
    check("done_once", done_cnt - d0, 1);
    check("dest_writes", ch ? wr_4 - w0_4 : wr_2 - w0_2, FRAME_LEN);
    check("other_writes", ch ? wr_2 - w0_2 : wr_4 - w0_4, 0);
    check("frame_reads", ch ? rd_b - r0_b : rd_a - r0_a, FRAME_LEN);
    if (!keep_start) begin
      tick(); settle();
      check("idle_after", bus.busy, 0);
    end
  endtask

  task automatic apply_round(input stim_t s, input int stall_at, input int stall_pct,
                             input int abort_at, input bit idle_drain);
    bit ea, eb;
    tick();
    drive(s);
    bus.fft_valid_out = 1'b0;
    settle();
    ea = eligible(s.u1a, s.e1a, s.u2, s.f2);
    eb = eligible(s.u1b, s.e1b, s.u4, s.f4);
    if (s.st && (ea || eb)) do_frame(pick(ea, eb), 1'b0, stall_at, stall_pct, abort_at, idle_drain);
    else                    expect_idle(6, "no_grant");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    stim_t s;
    int w0;
    drive('{0, 1, 0, 1, 0, 0, 0, 0, 0});
    bus.fft_valid_out = 1'b0;
    settle();
    check("reset_outs", outs(), 0);
    tick();
    reset = 1'b1;
    settle();
    check("post_reset_outs", outs(), 0);

    // Tie-break: both eligible, 1a first, then 1b straight after DONE.
    tick();
    drive('{64, 0, 64, 0, 0, 0, 0, 0, 1});
    settle();
    do_frame(pick(1'b1, 1'b1), 1'b1, -1, 0, -1, 1'b0);
    do_frame(pick(1'b1, 1'b1), 1'b0, -1, 0, -1, 1'b0);

    // Under-fill on 1a, 1b unavailable.
    apply_round('{63, 0, 0, 1, 0, 0, 0, 0, 1}, -1, 0, -1, 1'b0);

    // Result FIFO 2Re one sample too full, then exactly at the room limit.
    apply_round('{64, 0, 0, 1, 65, 0, 0, 0, 1}, -1, 0, -1, 1'b0);
    tick();
    bus.usedw2Re = CNT_W'(64);
    settle();
    check("room_same_cycle", bus.busy, 0);
    tick(); settle();
    check("room_grant", bus.busy, 1);
    do_frame(pick(1'b1, 1'b0), 1'b0, -1, 0, -1, 1'b0);

    // Three-cycle empty stall after read 10.
    apply_round('{64, 0, 0, 1, 0, 0, 0, 0, 1}, 10, 0, -1, 1'b0);

    // Reset in DRAIN after 20 writes, then FFT output while IDLE.
    apply_round('{64, 0, 0, 1, 0, 0, 0, 0, 1}, -1, 0, 20, 1'b0);
    tick();
    reset = 1'b0;
    bus.fft_valid_out = 1'b1;
    bus.start = 1'b0;
    #1;
    check("abort_outs", outs(), 0);
    model_last = 1'b1;
    tick(); tick();
    reset = 1'b1;
    w0 = wr_2 + wr_4;
    for (int c = 0; c < FRAME_LEN; c++) begin tick(); settle(); end
    check("idle_valid_no_wr", wr_2 + wr_4 - w0, 0);
    check("idle_valid_busy", bus.busy, 0);
    tick();
    bus.fft_valid_out = 1'b0;

    // Drain starvation: watchdog trip when enabled, indefinite wait otherwise.
    apply_round('{64, 0, 0, 1, 0, 0, 0, 0, 1}, -1, 0, -1, 1'b1);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      s.u1a = $urandom_range(72, 58); s.e1a = ($urandom_range(99) < 15);
      s.u1b = $urandom_range(72, 58); s.e1b = ($urandom_range(99) < 15);
      s.u2  = $urandom_range(70, 58); s.f2  = ($urandom_range(99) < 10);
      s.u4  = $urandom_range(70, 58); s.f4  = ($urandom_range(99) < 10);
      s.st  = ($urandom_range(99) < 80);
      apply_round(s, -1, 20, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL sim_timeout: bench did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
